// File: rtl/fmdll_lock_ctrl.sv
// Lock controller for the frequency-multiplying DLL: ratio check, SAR coarse search, filtered tracking.
// Latency: all outputs registered, one clk_ext after the deciding input; SAR takes CODE_W*SETTLE cycles.
// Backpressure: none; pd_up/pd_dn are sampled every cycle. Optional debug ports under FMDLL_LOCK_DBG_EN.
module fmdll_lock_ctrl #(
  parameter int CODE_W   = 6,
  parameter int SETTLE   = 4,
  parameter int FILT_MAX = 8,
  parameter int LOCK_CYC = 32
) (
  input  logic              clk_ext,
  input  logic              rst_n,
  input  logic [1:0]        M,
  input  logic [3:0]        N,
  input  logic              pd_up,
  input  logic              pd_dn,
  output logic [1:0]        Sel,
  output logic [CODE_W-1:0] dly_code,
  output logic              locked,
`ifdef FMDLL_LOCK_DBG_EN
  output logic [2:0]        dbg_state,
  output logic [7:0]        step_cnt,
`endif
  output logic              cfg_err
);

  localparam int FW = $clog2(FILT_MAX) + 2;
  localparam int IW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int LW = $clog2(LOCK_CYC + 1);

  localparam logic signed [FW-1:0] FMAX_P   = FW'(FILT_MAX);
  localparam logic signed [FW-1:0] FMAX_N   = -FMAX_P;
  localparam logic signed [FW-1:0] F_ONE    = FW'(1);
  localparam logic [SW-1:0]        SET_LAST = SW'(SETTLE - 1);
  localparam logic [LW-1:0]        LOCK_MAX = LW'(LOCK_CYC);
  localparam logic [IW-1:0]        IDX_MSB  = IW'(CODE_W - 1);
  localparam logic [CODE_W-1:0]    CODE_MID = CODE_W'(1) << (CODE_W - 1);
  localparam logic [CODE_W-1:0]    CODE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_SAR   = 3'd2,
    S_TRACK = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sel_q, sel_d;
  logic [CODE_W-1:0]      code_q, code_d;
  logic                   locked_q, locked_d;
  logic                   err_q, err_d;
  logic [1:0]             cfg_m_q, cfg_m_d;
  logic [3:0]             cfg_n_q, cfg_n_d;
  logic signed [FW-1:0]   filt_q, filt_d;
  logic [LW-1:0]          lock_cnt_q, lock_cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [SW-1:0]          settle_q, settle_d;
  logic [7:0]             steps_q, steps_d;
  logic                   cfg_chg;
  logic [CODE_W-1:0]      code_tmp;
  logic [IW-1:0]          idx_m1;

  // Supported ratios: M in 1..3, N in {1,4,5,8,10}.
  function automatic logic cfg_ok(input logic [1:0] m, input logic [3:0] n);
    return (m != 2'd0) &&
           (n == 4'd1 || n == 4'd4 || n == 4'd5 || n == 4'd8 || n == 4'd10);
  endfunction

  // Register all controller state; async reset returns to the idle/zero state.
  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      code_q     <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      cfg_m_q    <= '0;
      cfg_n_q    <= '0;
      filt_q     <= '0;
      lock_cnt_q <= '0;
      idx_q      <= '0;
      settle_q   <= '0;
      steps_q    <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      code_q     <= code_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      cfg_m_q    <= cfg_m_d;
      cfg_n_q    <= cfg_n_d;
      filt_q     <= filt_d;
      lock_cnt_q <= lock_cnt_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      steps_q    <= steps_d;
    end
  end

  // Next-state and datapath updates; a ratio change outranks any SAR/track update.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    code_d     = code_q;
    locked_d   = locked_q;
    err_d      = err_q;
    cfg_m_d    = cfg_m_q;
    cfg_n_d    = cfg_n_q;
    filt_d     = filt_q;
    lock_cnt_d = lock_cnt_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    steps_d    = steps_q;
    cfg_chg    = (M != cfg_m_q) || (N != cfg_n_q);
    code_tmp   = code_q;
    idx_m1     = idx_q - IW'(1);

    case (state_q)
      S_IDLE: begin
        state_d = S_CHECK;
        cfg_m_d = M;
        cfg_n_d = N;
      end

      S_CHECK, S_SAR, S_TRACK: begin
        if (cfg_chg) begin
          locked_d = 1'b0;
          state_d  = S_CHECK;
          cfg_m_d  = M;
          cfg_n_d  = N;
        end else if (state_q == S_CHECK) begin
          locked_d = 1'b0;
          steps_d  = '0;
          if (cfg_ok(cfg_m_q, cfg_n_q)) begin
            sel_d    = cfg_m_q - 2'd1;
            code_d   = CODE_MID;
            idx_d    = IDX_MSB;
            settle_d = '0;
            state_d  = S_SAR;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end else if (state_q == S_SAR) begin
          if (settle_q == SET_LAST) begin
            settle_d = '0;
            if (!pd_up) code_tmp[idx_q] = 1'b0;
            if (idx_q == '0) begin
              state_d    = S_TRACK;
              filt_d     = '0;
              lock_cnt_d = '0;
            end else begin
              code_tmp[idx_m1] = 1'b1;
              idx_d            = idx_m1;
            end
            code_d = code_tmp;
          end else begin
            settle_d = settle_q + SW'(1);
          end
        end else begin
          if (filt_q == FMAX_P || filt_q == FMAX_N) begin
            if ((filt_q == FMAX_P && code_q == CODE_MAX) ||
                (filt_q == FMAX_N && code_q == '0)) begin
              // Delay line ran out of range: drop the step and search again.
              locked_d   = 1'b0;
              state_d    = S_SAR;
              code_d     = CODE_MID;
              idx_d      = IDX_MSB;
              settle_d   = '0;
              filt_d     = '0;
              lock_cnt_d = '0;
            end else begin
              code_d     = (filt_q == FMAX_P) ? code_q + CODE_W'(1) : code_q - CODE_W'(1);
              filt_d     = '0;
              lock_cnt_d = '0;
              if (steps_q != 8'hFF) steps_d = steps_q + 8'd1;
            end
          end else begin
            if (pd_up && !pd_dn)      filt_d = filt_q + F_ONE;
            else if (pd_dn && !pd_up) filt_d = filt_q - F_ONE;
            if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + LW'(1);
            if (lock_cnt_d == LOCK_MAX) locked_d = 1'b1;
          end
        end
      end

      S_ERR: begin
        locked_d = 1'b0;
        if (cfg_ok(M, N)) begin
          err_d   = 1'b0;
          state_d = S_CHECK;
          cfg_m_d = M;
          cfg_n_d = N;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign Sel      = sel_q;
  assign dly_code = code_q;
  assign locked   = locked_q;
  assign cfg_err  = err_q;

`ifdef FMDLL_LOCK_DBG_EN
  assign dbg_state = state_q;
  assign step_cnt  = steps_q;
`else
  logic unused_steps;
  assign unused_steps = ^steps_q;
`endif

endmodule

// File: tb/tb_fmdll_lock_ctrl.sv
// Self-checking bench for fmdll_lock_ctrl: directed scenarios plus a randomized closed loop.
// Latency: outputs compared 1 ns after every clk_ext rising edge against a behavioural model.
// Backpressure: none; pd inputs come from a simple plant model of the delay line.
module tb_fmdll_lock_ctrl;

  localparam int CODE_W   = 6;
  localparam int SETTLE   = 4;
  localparam int FILT_MAX = 8;
  localparam int LOCK_CYC = 32;
  localparam int MAXC     = (1 << CODE_W) - 1;
  localparam int MIDC     = 1 << (CODE_W - 1);

  logic              clk_ext = 1'b0;
  logic              rst_n;
  logic [1:0]        M;
  logic [3:0]        N;
  logic              pd_up, pd_dn;
  logic [1:0]        Sel;
  logic [CODE_W-1:0] dly_code;
  logic              locked, cfg_err;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0 idle, 1 check, 2 search, 3 track, 4 error.
  int m_ph, m_code, m_sel, m_locked, m_err, m_cfgm, m_cfgn, m_filt, m_quiet, m_sar_t;

  fmdll_lock_ctrl #(
    .CODE_W(CODE_W), .SETTLE(SETTLE), .FILT_MAX(FILT_MAX), .LOCK_CYC(LOCK_CYC)
  ) dut (
    .clk_ext(clk_ext), .rst_n(rst_n), .M(M), .N(N), .pd_up(pd_up), .pd_dn(pd_dn),
    .Sel(Sel), .dly_code(dly_code), .locked(locked), .cfg_err(cfg_err)
  );

  always #5 clk_ext = ~clk_ext;

  function automatic bit valid_cfg(input int m, input int n);
    return (m >= 1 && m <= 3) && (n == 1 || n == 4 || n == 5 || n == 8 || n == 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_code = 0; m_sel = 0; m_locked = 0; m_err = 0;
    m_cfgm = 0; m_cfgn = 0; m_filt = 0; m_quiet = 0; m_sar_t = 0;
  endtask

  task automatic model_step(input int mi, input int ni, input int up, input int dn);
    int b;
    case (m_ph)
      0: begin m_ph = 1; m_cfgm = mi; m_cfgn = ni; end
      4: begin
        m_locked = 0;
        if (valid_cfg(mi, ni)) begin m_err = 0; m_ph = 1; m_cfgm = mi; m_cfgn = ni; end
      end
      default: begin
        if (mi != m_cfgm || ni != m_cfgn) begin
          m_locked = 0; m_ph = 1; m_cfgm = mi; m_cfgn = ni;
        end else if (m_ph == 1) begin
          m_locked = 0;
          if (valid_cfg(m_cfgm, m_cfgn)) begin
            m_sel = m_cfgm - 1; m_code = MIDC; m_sar_t = 0; m_ph = 2;
          end else begin
            m_err = 1; m_ph = 4;
          end
        end else if (m_ph == 2) begin
          // Bit under test is fixed by elapsed search time; decide on the last settle cycle.
          b = CODE_W - 1 - m_sar_t / SETTLE;
          if (m_sar_t % SETTLE == SETTLE - 1) begin
            if (up == 0) m_code = m_code & ~(1 << b);
            if (b == 0) begin m_ph = 3; m_filt = 0; m_quiet = 0; end
            else m_code = m_code | (1 << (b - 1));
          end
          m_sar_t++;
        end else begin
          if ((m_filt == FILT_MAX && m_code == MAXC) || (m_filt == -FILT_MAX && m_code == 0)) begin
            m_locked = 0; m_ph = 2; m_code = MIDC; m_sar_t = 0; m_filt = 0; m_quiet = 0;
          end else if (m_filt == FILT_MAX || m_filt == -FILT_MAX) begin
            m_code = m_code + (m_filt > 0 ? 1 : -1); m_filt = 0; m_quiet = 0;
          end else begin
            m_filt = m_filt + ((up != 0 && dn == 0) ? 1 : 0) - ((dn != 0 && up == 0) ? 1 : 0);
            m_quiet = (m_quiet + 1 > LOCK_CYC) ? LOCK_CYC : m_quiet + 1;
            if (m_quiet == LOCK_CYC) m_locked = 1;
          end
        end
      end
    endcase
  endtask

  task automatic cyc();
    @(posedge clk_ext);
    #1;
    model_step(int'(M), int'(N), int'(pd_up), int'(pd_dn));
    chk("sel", 32'(Sel), 32'(m_sel));
    chk("dly_code", 32'(dly_code), 32'(m_code));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  // Plant: phase detector compares the model's code with a target, with optional noise.
  task automatic plant(input int tgt, input int noise_pct);
    if (m_code < tgt)      begin pd_up = 1'b1; pd_dn = 1'b0; end
    else if (m_code > tgt) begin pd_up = 1'b0; pd_dn = 1'b1; end
    else begin pd_up = 1'($urandom_range(0, 1)); pd_dn = pd_up; end
    if ($urandom_range(0, 99) < noise_pct) begin
      pd_up = 1'($urandom_range(0, 1));
      pd_dn = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int snap;
    int tgt;
    rst_n = 1'b0; M = 2'd3; N = 4'd10; pd_up = 1'b0; pd_dn = 1'b0;
    model_reset();
    #12;
    chk("rst_sel", 32'(Sel), 0);
    chk("rst_code", 32'(dly_code), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    @(negedge clk_ext);
    rst_n = 1'b1;

    // pd_up stuck high: search ends at full scale, then up-steps saturate and restart.
    pd_up = 1'b1;
    repeat (26) cyc();
    chk("sar_all_up_code", 32'(dly_code), 63);
    chk("sar_all_up_sel", 32'(Sel), 2);
    repeat (9) cyc();
    chk("sat_restart_code", 32'(dly_code), 32);
    chk("sat_locked", 32'(locked), 0);

    // New ratio mid-search; plant settles just below 21 so the search lands on 20.
    M = 2'd2; N = 4'd8;
    for (int i = 0; i < 26; i++) begin
      pd_up = (m_code < 21); pd_dn = !(m_code < 21);
      cyc();
    end
    chk("sar_20_code", 32'(dly_code), 20);
    chk("sar_20_sel", 32'(Sel), 1);
    for (int i = 0; i < 40; i++) begin
      pd_up = (m_code < 21); pd_dn = !(m_code < 21);
      cyc();
      chk("dither_range", 32'(dly_code >= 20 && dly_code <= 21), 1);
    end

    // Both detector outputs high: filter holds, lock must appear.
    pd_up = 1'b1; pd_dn = 1'b1;
    cyc();
    snap = m_code;
    repeat (99) cyc();
    chk("balanced_locked", 32'(locked), 1);
    chk("balanced_code", 32'(dly_code), 32'(snap));

    // Ratio change while locked drops lock immediately and reruns the search.
    N = 4'd5;
    cyc();
    chk("chg_unlock", 32'(locked), 0);
    cyc();
    chk("chg_restart", 32'(dly_code), 32);

    // Unsupported ratios park in the error state with the code frozen.
    M = 2'd0;
    repeat (2) cyc();
    chk("err_set", 32'(cfg_err), 1);
    chk("err_code_hold", 32'(dly_code), 32);
    M = 2'd2; N = 4'd7;
    repeat (5) cyc();
    chk("err_n7", 32'(cfg_err), 1);
    N = 4'd4;
    cyc();
    chk("err_clear", 32'(cfg_err), 0);
    cyc();
    chk("err_exit_sel", 32'(Sel), 1);
    chk("err_exit_code", 32'(dly_code), 32);

    // Asynchronous reset mid-search.
    M = 2'd3; N = 4'd1;
    pd_up = 1'b1; pd_dn = 1'b0;
    repeat (10) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(Sel), 0);
    chk("arst_code", 32'(dly_code), 0);
    chk("arst_locked", 32'(locked), 0);
    #2 rst_n = 1'b1;
    model_reset();
    cyc();
    chk("arst_check_code", 32'(dly_code), 0);
    cyc();
    chk("arst_sar_code", 32'(dly_code), 32);
    chk("arst_sar_sel", 32'(Sel), 2);

    // Randomized closed loop with occasional ratio changes, including invalid ones.
    for (int ep = 0; ep < 24; ep++) begin
      tgt = $urandom_range(0, MAXC);
      if ($urandom_range(0, 3) == 0) begin
        M = 2'($urandom_range(0, 3));
        N = 4'($urandom_range(0, 10));
      end
      for (int i = 0; i < 150; i++) begin
        plant(tgt, (ep % 3 == 0) ? 30 : 5);
        cyc();
      end
      if (m_ph == 4) begin
        M = 2'd1; N = 4'd5;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
